// File: rtl/instr_encoder32.sv
// ---------------------------------------------------------------------------
// instr_encoder32
//
// Packs MIPS instruction descriptors into 32-bit words and writes them
// sequentially into instruction memory. A session opens with a start
// pulse, which latches base_addr, and closes with a finish pulse.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, base_addr    open a session at the given imem word address
//   finish              close the session (done pulses one cycle later)
//   in_valid/in_ready   descriptor handshake (in_ready = session in LOAD)
//   in_class, in_rs, in_rt, in_rd, in_shamt, in_funct, in_imm, in_target
//                       descriptor: class selects which fields are packed
//   imem_we/addr/wdata  registered imem write port
//   busy                session open (LOAD or FULL)
//   done                one-cycle pulse when a session closes
//   illegal             one-cycle pulse after a class-7 descriptor is taken
//   overflow            sticky: a descriptor was offered while FULL
//   count               words written in the current/last session
// ---------------------------------------------------------------------------
module instr_encoder32 #(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              finish,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FULL = 2'd2
  } state_t;

  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  localparam logic [2:0] C_R    = 3'd0;
  localparam logic [2:0] C_ADDI = 3'd1;
  localparam logic [2:0] C_LW   = 3'd2;
  localparam logic [2:0] C_SW   = 3'd3;
  localparam logic [2:0] C_BEQ  = 3'd4;
  localparam logic [2:0] C_BNE  = 3'd5;
  localparam logic [2:0] C_J    = 3'd6;
  localparam logic [2:0] C_ILL  = 3'd7;

  state_t              state_q;
  logic [ADDR_W-1:0]   wr_ptr_q;
  logic [ADDR_W:0]     count_q;
  logic [ADDR_W:0]     count_d;
  logic                imem_we_q;
  logic [ADDR_W-1:0]   imem_addr_q;
  logic [31:0]         imem_wdata_q;
  logic                done_q;
  logic                illegal_q;
  logic                overflow_q;
  logic [31:0]         enc_word_d;

  // Field packing. Fields a class does not use are simply not routed.
  always_comb begin
    enc_word_d = 32'h0;
    case (in_class)
      C_R:    enc_word_d = {6'b000000, in_rs, in_rt, in_rd, in_shamt, in_funct};
      C_ADDI: enc_word_d = {6'b001000, in_rs, in_rt, in_imm};
      C_LW:   enc_word_d = {6'b100011, in_rs, in_rt, in_imm};
      C_SW:   enc_word_d = {6'b101011, in_rs, in_rt, in_imm};
      C_BEQ:  enc_word_d = {6'b000100, in_rs, in_rt, in_imm};
      C_BNE:  enc_word_d = {6'b000101, in_rs, in_rt, in_imm};
      C_J:    enc_word_d = {6'b000010, in_target};
      default: enc_word_d = 32'h0;
    endcase
  end

  assign count_d = count_q + CNT_ONE;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= 32'h0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      // Pulse outputs default low; address/data hold their last value.
      imem_we_q <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // finish alone is ignored here; start wins if both arrive.
          if (start) begin
            state_q    <= S_LOAD;
            wr_ptr_q   <= base_addr;
            count_q    <= '0;
            overflow_q <= 1'b0;
          end
        end
        S_LOAD: begin
          // in_ready is high throughout LOAD, so in_valid alone is a transfer.
          if (in_valid) begin
            if (in_class == C_ILL) begin
              illegal_q <= 1'b1;
            end else begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= wr_ptr_q;
              imem_wdata_q <= enc_word_d;
              wr_ptr_q     <= wr_ptr_q + PTR_ONE;
              count_q      <= count_d;
              if (count_d == DEPTH_C) begin
                state_q <= S_FULL;
              end
            end
          end
          // A coincident finish still lets the descriptor above be written.
          if (finish) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        S_FULL: begin
          if (in_valid) begin
            overflow_q <= 1'b1;
          end
          if (finish) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q != S_IDLE);
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign done       = done_q;
  assign illegal    = illegal_q;
  assign overflow   = overflow_q;
  assign count      = count_q;

endmodule

// File: doc/instr_encoder32.md
Name: instr_encoder32

Overview:
- Instruction producer for the single-cycle MIPS datapath: the write-side counterpart of the opcode decoder.
- Accepts instruction descriptors (class plus fields) over a valid/ready handshake.
- Packs each into a 32-bit MIPS word and writes it sequentially into instruction memory starting at a programmed base word address.
- Used by the program loader and testbenches to fill imem before the core is released from reset.

Parameters:
- ADDR_W, 8, width of the imem word address.
- DEPTH, 256, number of words the loader may write per session, 1..2^ADDR_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  pulse: begin a load session at base_addr
- base_addr  in  ADDR_W  first imem word address
- finish  in  1  pulse: end the session
- in_valid  in  1  descriptor valid
- in_ready  out  1  encoder accepts a descriptor this cycle
- in_class  in  3  0=R, 1=ADDI, 2=LW, 3=SW, 4=BEQ, 5=BNE, 6=J, 7=illegal
- in_rs  in  5  source register
- in_rt  in  5  target register
- in_rd  in  5  destination register (R only)
- in_shamt  in  5  shift amount (R only)
- in_funct  in  6  function code (R only)
- in_imm  in  16  immediate/offset (I types)
- in_target  in  26  jump target (J)
- imem_we  out  1  imem write strobe
- imem_addr  out  ADDR_W  imem word address
- imem_wdata  out  32  encoded instruction
- busy  out  1  session active (LOAD or FULL)
- done  out  1  one-cycle pulse when a session ends
- illegal  out  1  one-cycle pulse, class 7 accepted
- overflow  out  1  sticky: descriptor offered while FULL
- count  out  ADDR_W+1  words written this session

Behaviour:
- Reset: state=IDLE. in_ready, imem_we, busy, done, illegal, overflow=0. imem_addr, imem_wdata, count=0. A write pending at reset is dropped.
- States: IDLE, LOAD, FULL.
  - IDLE -> LOAD on start: wr_ptr<=base_addr, count<=0, overflow<=0.
  - LOAD -> FULL when the accepted descriptor makes count reach DEPTH.
  - LOAD/FULL -> IDLE on finish; done pulses on the following cycle.
  - start while busy is ignored.
  - finish in IDLE is ignored (no done).
- in_ready = (state==LOAD). It is combinational from state only and never depends on in_valid.
- Handshake: transfer when in_valid & in_ready at a rising edge. Throughput is one descriptor per cycle, no bubbles.
- Latency:
  - A descriptor accepted at edge N is presented in the cycle after edge N: imem_we=1, imem_addr=wr_ptr, imem_wdata=encoded word.
  - wr_ptr and count increment at edge N.
  - imem_we is low in every other cycle.
- Encoding: op is bits 31:26.
  - R: {000000, rs, rt, rd, shamt, funct}.
  - ADDI 001000, LW 100011, SW 101011, BEQ 000100, BNE 000101: {op, rs, rt, imm}.
  - J: {000010, target}.
  - Unused fields are ignored.
- Illegal class 7: consumes the handshake and pulses illegal the following cycle. No write; wr_ptr and count are unchanged.
- wr_ptr wraps modulo 2^ADDR_W. count does not wrap; it saturates the session at DEPTH through the FULL state.
- FULL: in_ready=0. Any in_valid high in FULL sets overflow, which holds until the next start or reset.
- finish on the same edge as an accepted descriptor: the descriptor is written, then the state goes IDLE and done pulses. Both the write and done appear in the same next cycle.
- start and finish on the same edge in IDLE: start wins, finish is ignored.
- count holds its final value after the session until the next start.

Test Plan:
- start base=0x10, then R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> next cycle imem_we=1, addr=0x10, wdata=0x00221820; count=1.
- Back-to-back, in_valid held for three cycles:
  - ADDI rs=0 rt=5 imm=0xFFFF -> 0x2005FFFF @0x11
  - LW rs=29 rt=8 imm=4 -> 0x8FA80004 @0x12
  - J target=0x0000010 -> 0x08000010 @0x13
  - Expect three consecutive imem_we cycles and count=4.
- BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF. Then class 7 -> illegal pulse, no imem_we, count unchanged. Then BNE rs=1 rt=2 imm=0xFFFF -> 0x1422FFFF at the next consecutive address.
- DEPTH=4, base=0xFE, five descriptors:
  - writes land at 0xFE, 0xFF, 0x00, 0x01 (wrap).
  - in_ready drops after the 4th; overflow=1 while the 5th is offered.
  - finish -> done pulse, busy=0.
- Assert reset the cycle after an accepted descriptor -> imem_we stays 0, state IDLE, count=0, in_ready=0. A following start resumes normally.
- finish coincident with an accepted SW rs=2 rt=3 imm=8 -> wdata=0xAC430008 written and done pulses in the same cycle. A later start clears overflow and count.
